csla_bec_pipe: RTL and testbench
================================

# csla_bec_pipe

Parametrised, pipelined carry-select adder using binary-to-excess-1 converters (BEC). It generalises the fixed 32-bit CSLA/BEC adder family to any width, group size and pipeline depth. It adds a valid/ready handshake so it can sit in the Karatsuba partial-product accumulation datapath at full clock rate. Each pipeline stage adds one slice of the operands and registers the slice carry into the next stage.

## Interface
- `WIDTH`, default 32: operand and sum width. Must be a multiple of `GROUP*STAGES`.
- `GROUP`, default 4: bits per CSLA group (one RCA plus BEC select unit).
- `STAGES`, default 2: number of pipeline stages, ≥1. Each stage covers `SLICE = WIDTH/STAGES` bits.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: the adder accepts operands this cycle.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry in.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  WIDTH: registered result, equal to `(a+b+cin) mod 2^WIDTH`.
- `cout`  out  1: registered carry out of bit `WIDTH-1`.

## Operation
- Stage k (0..STAGES-1) adds bits `[k*SLICE +: SLICE]` of the in-flight operands.
  - Its carry in is the registered carry from stage k-1; stage 0 uses `cin`.
- Within a stage, the slice is a chain of `csla_bec_group` instances:
  - The lowest group is a plain RCA.
  - Each higher group computes an RCA sum with carry 0, plus a BEC (+1) of that sum.
  - The incoming group carry selects between them, as in the combinational CSLA/BEC.
- Each pipeline register holds:
  - a valid bit;
  - the not-yet-added upper operand bits;
  - the already-computed lower sum bits (skew/deskew);
  - one carry bit.
- The final stage register drives `sum`, `cout` and `out_valid` directly.
- Global enable `en = !out_valid || out_ready`. `in_ready = en`.
- When `en=1`, every stage register advances. Stage 0 loads `in_valid` and its data.
- When `en=0`, all stages hold. Bubbles are not collapsed.
- A transfer happens on `in_valid && in_ready` (input side) and on `out_valid && out_ready` (output side). A simultaneous input and output transfer in the same cycle is legal and sustains 1 result per cycle.
- Data registers load only when their incoming valid is 1. Invalid slots keep their old data, which reduces toggling.
- Overflow wraps modulo `2^WIDTH`. The carry is reported only on `cout`.

## Timing
- Latency: exactly `STAGES` cycles from the input handshake to `out_valid=1`, when there is no stall.
- Throughput: 1 operation per cycle while `out_ready=1`.
- Reset values while `rst_n=0`: all valid bits 0, `out_valid=0`, `sum=0`, `cout=0`, all internal carries 0.
  - `in_ready=1` during and after reset, since `out_valid=0`.
- Reset asserted mid-operation discards all in-flight results. No output handshake occurs for them.
- Output data (`sum`, `cout`) must remain stable while `out_valid=1 && out_ready=0`.
- Critical path per stage: one GROUP-bit RCA, plus one BEC, plus `SLICE/GROUP` carry-select muxes.

## Structure
- Package `csla_pkg`:
  - function `num_groups(width, group)`;
  - elaboration-time checks that `WIDTH % (GROUP*STAGES) == 0` and `STAGES ≥ 1`.
- Sub-module `csla_bec_group #(GROUP)`:
  - inputs `a`, `b`, `c`; outputs `s`, `co`;
  - internally one RCA and one GROUP-bit BEC with mux;
  - purely combinational.
- Top level: a generate loop over stages and groups, plus the stage register array.

## Test plan
- After reset release, with `STAGES=2`: drive `a=32'h0100DABC`, `b=32'h56876542`, `cin=0`. After 2 cycles, require `sum=32'h57883FFE`, `cout=0`.
- Full carry ripple across all stage boundaries: `a=32'hFFFFFFFF`, `b=0`, `cin=1` → `sum=0`, `cout=1`. Repeat with `a=b=32'hFFFFFFFF`, `cin=1` → `sum=32'hFFFFFFFF`, `cout=1`.
- Back-to-back stream of 8 random operand pairs with `out_ready=1`:
  - one result per cycle, in order, matching a reference model.
- Backpressure: hold `out_ready=0` for 5 cycles during the stream.
  - `in_ready=0` whenever `out_valid=1`; `sum` is stable; no result is lost or duplicated.
- Assert `rst_n=0` while 2 operations are in flight:
  - `out_valid` drops asynchronously; `sum=0`; no stale result appears after release.
- Parameter sweep (`WIDTH`/`GROUP`/`STAGES`) = 16/4/1, 32/4/4, 64/8/2:
  - random operands; results are bit-exact against `a+b+cin`;
  - latency equals `STAGES`.

Source files
------------

// File: rtl/csla_pkg.sv
// csla_pkg: shared helpers for the pipelined CSLA/BEC adder.
// Group counting and configuration legality.
package csla_pkg;

  function automatic int num_groups(int width, int group);
    return width / group;
  endfunction

  function automatic bit cfg_ok(int width, int group, int stages);
    if (stages < 1 || group < 1) return 1'b0;
    return (width % (group * stages)) == 0;
  endfunction

endpackage

// File: rtl/csla_bec_group.sv
// csla_bec_group: one carry-select group, RCA with carry 0 plus
// a binary-to-excess-1 converter, selected by the incoming carry.
module csla_bec_group #(
  parameter int GROUP = 4,
  parameter int PLAIN = 0
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c,
  output logic [GROUP-1:0] s,
  output logic             co
);

  if (PLAIN != 0) begin : g_rca
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{GROUP{1'b0}}, c};
  end else begin : g_bec
    logic [GROUP-1:0] x;
    logic [GROUP-1:0] x1;
    logic             c0;
    logic             c1;
    logic             t;

    assign {c0, x} = {1'b0, a} + {1'b0, b};

    // BEC: bit i flips when every lower bit is 1
    always_comb begin
      x1 = '0;
      t  = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        x1[i] = x[i] ^ t;
        t     = t & x[i];
      end
      c1 = c0 | t;
    end

    assign s  = c ? x1 : x;
    assign co = c ? c1 : c0;
  end

endmodule

// File: rtl/csla_bec_pipe.sv
// csla_bec_pipe: pipelined carry-select adder, one slice per stage,
// with a global-stall valid/ready handshake.
module csla_bec_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NG    = num_groups(SLICE, GROUP);

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
    $error("csla_bec_pipe: illegal WIDTH/GROUP/STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] pa [STAGES+1];
  logic [WIDTH-1:0] pb [STAGES+1];
  logic [WIDTH-1:0] ps [STAGES+1];
  logic             pc [STAGES+1];
  logic             pv [STAGES+1];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign pa[0] = a;
  assign pb[0] = b;
  assign ps[0] = '0;
  assign pc[0] = cin;
  assign pv[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [NG:0]      gc;
    logic [SLICE-1:0] ss;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             rc;
    logic             rv;

    assign gc[0] = pc[k];

    for (genvar g = 0; g < NG; g++) begin : g_grp
      csla_bec_group #(
        .GROUP (GROUP),
        .PLAIN ((g == 0) ? 1 : 0)
      ) u_grp (
        .a  (pa[k][k*SLICE+g*GROUP +: GROUP]),
        .b  (pb[k][k*SLICE+g*GROUP +: GROUP]),
        .c  (gc[g]),
        .s  (ss[g*GROUP +: GROUP]),
        .co (gc[g+1])
      );
    end

    // deskew: lower slices already summed, this slice fills in
    always_comb begin
      nxt = ps[k];
      nxt[k*SLICE +: SLICE] = ss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv <= 1'b0;
        rc <= 1'b0;
        ra <= '0;
        rb <= '0;
        rs <= '0;
      end else if (en) begin
        rv <= pv[k];
        if (pv[k]) begin
          ra <= pa[k];
          rb <= pb[k];
          rs <= nxt;
          rc <= gc[NG];
        end
      end
    end

    assign pa[k+1] = ra;
    assign pb[k+1] = rb;
    assign ps[k+1] = rs;
    assign pc[k+1] = rc;
    assign pv[k+1] = rv;
  end

  logic unused_ops;
  assign unused_ops = ^{pa[STAGES], pb[STAGES]};

  assign out_valid = pv[STAGES];
  assign sum       = ps[STAGES];
  assign cout      = pc[STAGES];

endmodule

// File: tb/tb_csla_bec_pipe.sv
// tb_csla_bec_pipe: directed and random checks of the pipelined adder
// across four parameter sets sharing one stimulus stream.
module tb_csla_bec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;

  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0]  co;
  logic [63:0] sm [4];
  logic [31:0] s0;
  logic [15:0] s1;
  logic [31:0] s2;
  logic [63:0] s3;

  localparam int W [4] = '{32, 16, 32, 64};
  localparam int S [4] = '{2, 1, 4, 2};

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csla_bec_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin), .out_valid(ov[0]),
    .out_ready(out_ready), .sum(s0), .cout(co[0]));

  csla_bec_pipe #(.WIDTH(16), .GROUP(4), .STAGES(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .out_valid(ov[1]),
    .out_ready(out_ready), .sum(s1), .cout(co[1]));

  csla_bec_pipe #(.WIDTH(32), .GROUP(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin), .out_valid(ov[2]),
    .out_ready(out_ready), .sum(s2), .cout(co[2]));

  csla_bec_pipe #(.WIDTH(64), .GROUP(8), .STAGES(2)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a_in), .b(b_in), .cin(cin), .out_valid(ov[3]),
    .out_ready(out_ready), .sum(s3), .cout(co[3]));

  assign sm[0] = {32'd0, s0};
  assign sm[1] = {48'd0, s1};
  assign sm[2] = {32'd0, s2};
  assign sm[3] = s3;

  // reference: bit w of the result is the carry out
  function automatic logic [64:0] model(int w, logic [63:0] x,
                                        logic [63:0] y, logic c);
    logic [64:0] m;
    logic [64:0] r;
    m = (w == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
    r = ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, c};
    return r & ((m << 1) | 65'd1);
  endfunction

  task automatic chk(input string name, input logic [64:0] act,
                     input logic [64:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  logic [64:0] eq [4][$];
  int          tq [4][$];
  logic [63:0] hold_sum [4];
  bit          stalled [4];
  int          last_stall [4];

  always @(negedge clk) begin : compare_p
    logic [64:0] e;
    logic [64:0] act;
    int          t;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          if (stalled[i]) chk($sformatf("hold_stable%0d", i),
                              {1'b0, sm[i]}, {1'b0, hold_sum[i]});
          if (out_ready) begin
            stalled[i] = 1'b0;
            if (eq[i].size() == 0) begin
              total++;
              $display("FAIL unexpected_out%0d actual=%h required=none",
                       i, sm[i]);
            end else begin
              e = eq[i].pop_front();
              t = tq[i].pop_front();
              act = {1'b0, sm[i]};
              act[W[i]] = co[i];
              chk($sformatf("result%0d", i), act, e);
              if (t > last_stall[i])
                chk($sformatf("latency%0d", i), 65'(cyc - t), 65'(S[i]));
            end
          end else begin
            chk($sformatf("in_ready_low%0d", i), {64'd0, rdy[i]}, 65'd0);
            stalled[i] = 1'b1;
            hold_sum[i] = sm[i];
            last_stall[i] = cyc;
          end
        end else begin
          stalled[i] = 1'b0;
        end
        if (in_valid && rdy[i]) begin
          eq[i].push_back(model(W[i], a_in, b_in, cin));
          tq[i].push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y,
                      input logic c);
    bit acc;
    int n;
    in_valid = 1'b1;
    a_in = x;
    b_in = y;
    cin = c;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdy[0];
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 65'd0, 65'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eq[i].delete();
      tq[i].delete();
      stalled[i] = 1'b0;
      last_stall[i] = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), {64'd0, ov[i]}, 65'd0);
      chk($sformatf("rst_ready%0d", i), {64'd0, rdy[i]}, 65'd1);
    end
    chk("rst_sum", {1'b0, sm[0]}, 65'd0);
    chk("rst_cout", {64'd0, co[0]}, 65'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {64'd0, rdy[0]}, 65'd1);

    chk("model_pin_add", model(32, 64'h0100DABC, 64'h56876542, 1'b0),
        65'h0_57883FFE);
    chk("model_pin_wrap", model(32, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1),
        65'h1_FFFFFFFF);

    send(64'h0100DABC, 64'h56876542, 1'b0);
    step();
    chk("dir_valid", {64'd0, ov[0]}, 65'd1);
    chk("dir_sum", {33'd0, s0}, 65'h57883FFE);
    chk("dir_cout", {64'd0, co[0]}, 65'd0);
    idle(5);

    send(64'h00000000FFFFFFFF, 64'h0, 1'b1);
    step();
    chk("ripple1_sum", {33'd0, s0}, 65'd0);
    chk("ripple1_cout", {64'd0, co[0]}, 65'd1);
    send(64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 1'b1);
    step();
    chk("ripple2_sum", {33'd0, s0}, 65'hFFFFFFFF);
    chk("ripple2_cout", {64'd0, co[0]}, 65'd1);
    send({64{1'b1}}, 64'h0, 1'b1);
    send({64{1'b1}}, {64{1'b1}}, 1'b1);
    idle(6);

    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    idle(6);

    fork
      begin
        for (int i = 0; i < 8; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    idle(8);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_drained%0d", i), 65'(eq[i].size()), 65'd0);

    send(64'h1234, 64'h5678, 1'b0);
    send(64'h9ABC, 64'hDEF0, 1'b1);
    do_reset();
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("async_drop%0d", i), {64'd0, ov[i]}, 65'd0);
    chk("async_sum", {1'b0, sm[0]}, 65'd0);
    step();
    step();
    rst_n = 1'b1;
    idle(6);
    chk("no_stale", {61'd0, ov}, 65'd0);

    for (int i = 0; i < 10; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    idle(8);
    for (int i = 0; i < 4; i++)
      chk($sformatf("final_drained%0d", i), 65'(eq[i].size()), 65'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
